// File: rtl/data_memory_wbuf_if.sv
// MEM-stage to data-memory bus: load/store request, load data, back-pressure
// and write-buffer status.
interface data_memory_wbuf_if #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int WBUF_DEPTH   = 4
);
  localparam int CW = $clog2(WBUF_DEPTH) + 1;

  logic                    dm_read_enable;
  logic [ADDRESS_SIZE-1:0] dm_read_address;
  logic [DATA_SIZE-1:0]    dm_read_data;
  logic                    dm_write_enable;
  logic [ADDRESS_SIZE-1:0] dm_write_address;
  logic [DATA_SIZE-1:0]    dm_write_data;
  logic                    dm_stall;
  logic [CW-1:0]           wbuf_count;
  logic                    wbuf_empty;

  modport master (
    output dm_read_enable, dm_read_address, dm_write_enable, dm_write_address, dm_write_data,
    input  dm_read_data, dm_stall, wbuf_count, wbuf_empty
  );

  modport slave (
    input  dm_read_enable, dm_read_address, dm_write_enable, dm_write_address, dm_write_data,
    output dm_read_data, dm_stall, wbuf_count, wbuf_empty
  );
endinterface

// File: rtl/data_memory_wbuf.sv
// Word-addressed data memory with an in-order posted write buffer draining on idle port cycles.
// DM_WBUF_FORWARD_EN: loads forward from the youngest matching buffer entry; otherwise they stall.
module data_memory_wbuf #(
  parameter int ADDRESS_SIZE = 32,
  parameter int DATA_SIZE    = 32,
  parameter int DEPTH_WORDS  = 1024,
  parameter int WBUF_DEPTH   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  data_memory_wbuf_if.slave     dm
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_SIZE-1:0] mem     [DEPTH_WORDS];
  logic [IW-1:0]        wb_idx  [WBUF_DEPTH];
  logic [DATA_SIZE-1:0] wb_data [WBUF_DEPTH];
  logic [PW-1:0]        head, tail;
  logic [CW-1:0]        count, count_nxt;
  logic                 empty_q;

  logic [IW-1:0] rd_idx, wr_idx;
  logic          full, hit, read_stall, stall, push, drain;
  logic [DATA_SIZE-1:0] fwd_data;
  logic [PW-1:0] slot;
  logic          unused_addr_bits;

  assign rd_idx = dm.dm_read_address[IW+1:2];
  assign wr_idx = dm.dm_write_address[IW+1:2];
  assign unused_addr_bits = ^{dm.dm_read_address[ADDRESS_SIZE-1:IW+2], dm.dm_read_address[1:0],
                              dm.dm_write_address[ADDRESS_SIZE-1:IW+2], dm.dm_write_address[1:0]};
  assign full   = (count == CW'(WBUF_DEPTH));

  // Walk oldest to youngest over valid entries so the youngest match wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    slot     = head;
    for (int k = 0; k < WBUF_DEPTH; k++) begin
      slot = head + PW'(k);
      if (CW'(k) < count && wb_idx[slot] == rd_idx) begin
        hit      = 1'b1;
        fwd_data = wb_data[slot];
      end
    end
  end

`ifdef DM_WBUF_FORWARD_EN
  assign read_stall      = 1'b0;
  assign dm.dm_read_data = (dm.dm_read_enable && hit) ? fwd_data : mem[rd_idx];
`else
  // A conflicting load holds off and releases the port so the buffer can drain under it.
  assign read_stall      = dm.dm_read_enable & hit;
  assign dm.dm_read_data = read_stall ? '0 : mem[rd_idx];
  logic unused_fwd;
  assign unused_fwd = ^fwd_data;
`endif

  // A full buffer can only make room when the port is free for a drain.
  assign stall     = (dm.dm_write_enable & full & dm.dm_read_enable) | read_stall;
  assign drain     = (count != '0) & (~dm.dm_read_enable | read_stall);
  assign push      = dm.dm_write_enable & ~stall;
  assign count_nxt = count + CW'(push) - CW'(drain);

  assign dm.dm_stall   = stall;
  assign dm.wbuf_count = count;
  assign dm.wbuf_empty = empty_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      empty_q <= 1'b1;
    end else begin
      if (push)  tail <= tail + 1'b1;
      if (drain) head <= head + 1'b1;
      count   <= count_nxt;
      empty_q <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && push) begin
      wb_idx[tail]  <= wr_idx;
      wb_data[tail] <= dm.dm_write_data;
    end
    if (!reset && drain) mem[wb_idx[head]] <= wb_data[head];
  end
endmodule

// File: tb/tb_data_memory_wbuf.sv
// Directed bench for data_memory_wbuf; expectations follow DM_WBUF_FORWARD_EN when defined.
module tb_data_memory_wbuf;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  data_memory_wbuf_if #(.ADDRESS_SIZE(32), .DATA_SIZE(32), .WBUF_DEPTH(4)) bus();

  data_memory_wbuf #(.ADDRESS_SIZE(32), .DATA_SIZE(32), .DEPTH_WORDS(1024), .WBUF_DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .dm    (bus)
  );

  int checks   = 0;
  int failures = 0;

`ifdef DM_WBUF_FORWARD_EN
  localparam int FWD = 1;
`else
  localparam int FWD = 0;
`endif

  task automatic cyc;
    @(posedge clock);
    #1;
  endtask

  task automatic drv(input logic re, input logic [31:0] ra, input logic we,
                     input logic [31:0] wa, input logic [31:0] wd);
    bus.dm_read_enable   = re;
    bus.dm_read_address  = ra;
    bus.dm_write_enable  = we;
    bus.dm_write_address = wa;
    bus.dm_write_data    = wd;
    #1;
  endtask

  // Holds current inputs, advancing until dm_stall drops or the budget runs out.
  task automatic wait_nostall(output int n);
    n = 0;
    while (bus.dm_stall === 1'b1 && n < 10) begin
      cyc;
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drv(0, 0, 0, 0, 0);
    cyc; cyc;
    reset = 1'b0;
    checks++; if (bus.wbuf_count !== 3'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", bus.wbuf_count); end
    checks++; if (bus.wbuf_empty !== 1'b1) begin failures++; $display("FAIL rst_empty got=%0b exp=1", bus.wbuf_empty); end
    checks++; if (bus.dm_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0b exp=0", bus.dm_stall); end
    // Seed array[0x10] then pile up 3 pending stores behind a held load.
    drv(0, 0, 1, 32'h10, 32'h1111_1111); cyc;
    drv(0, 0, 0, 0, 0); cyc;
    drv(1, 32'h40, 1, 32'h10, 32'hBAD0_0000); cyc;
    drv(1, 32'h40, 1, 32'h14, 32'hBAD0_0001); cyc;
    drv(1, 32'h40, 1, 32'h18, 32'hBAD0_0002); cyc;
    checks++; if (bus.wbuf_count !== 3'd3) begin failures++; $display("FAIL t1_pending got=%0d exp=3", bus.wbuf_count); end
    reset = 1'b1;
    drv(0, 0, 0, 0, 0); cyc;
    reset = 1'b0;
    checks++; if (bus.wbuf_count !== 3'd0) begin failures++; $display("FAIL t1_count got=%0d exp=0", bus.wbuf_count); end
    checks++; if (bus.wbuf_empty !== 1'b1) begin failures++; $display("FAIL t1_empty got=%0b exp=1", bus.wbuf_empty); end
    drv(1, 32'h10, 0, 0, 0);
    checks++; if (bus.dm_read_data !== 32'h1111_1111) begin failures++; $display("FAIL t1_load got=%h exp=11111111", bus.dm_read_data); end
    drv(0, 0, 0, 0, 0); cyc;
  endtask

  task automatic test_store_load;
    drv(0, 0, 1, 32'h10, 32'hDEAD_BEEF); cyc;
    checks++; if (bus.wbuf_empty !== 1'b0) begin failures++; $display("FAIL t2_notempty got=%0b exp=0", bus.wbuf_empty); end
    drv(1, 32'h10, 0, 0, 0);
    if (FWD == 1) begin
      checks++; if (bus.dm_stall !== 1'b0) begin failures++; $display("FAIL t2_stall got=%0b exp=0", bus.dm_stall); end
      checks++; if (bus.dm_read_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL t2_fwd got=%h exp=deadbeef", bus.dm_read_data); end
    end else begin
      checks++; if (bus.dm_stall !== 1'b1) begin failures++; $display("FAIL t2_stall got=%0b exp=1", bus.dm_stall); end
      checks++; if (bus.dm_read_data !== 32'h0) begin failures++; $display("FAIL t2_zero got=%h exp=0", bus.dm_read_data); end
      cyc;
      checks++; if (bus.dm_stall !== 1'b0) begin failures++; $display("FAIL t2_release got=%0b exp=0", bus.dm_stall); end
      checks++; if (bus.dm_read_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL t2_array got=%h exp=deadbeef", bus.dm_read_data); end
    end
    drv(0, 0, 0, 0, 0); cyc; cyc;
  endtask

  task automatic test_youngest_hit;
    int n;
    drv(1, 32'h40, 1, 32'h20, 32'd1); cyc;
    drv(1, 32'h40, 1, 32'h20, 32'd2); cyc;
    checks++; if (bus.wbuf_count !== 3'd2) begin failures++; $display("FAIL t3_count got=%0d exp=2", bus.wbuf_count); end
    drv(1, 32'h20, 0, 0, 0);
    wait_nostall(n);
    checks++; if (n != (FWD == 1 ? 0 : 2)) begin failures++; $display("FAIL t3_stall_cycles got=%0d exp=%0d", n, (FWD == 1 ? 0 : 2)); end
    checks++; if (bus.dm_read_data !== 32'd2) begin failures++; $display("FAIL t3_youngest got=%0d exp=2", bus.dm_read_data); end
    drv(0, 0, 0, 0, 0); cyc; cyc; cyc;
  endtask

  task automatic test_full_backpressure;
    for (int i = 0; i < 4; i++) begin
      drv(1, 32'h40, 1, 32'(i * 4), 32'h100 + 32'(i));
      checks++; if (bus.dm_stall !== 1'b0) begin failures++; $display("FAIL t4_nostall_%0d got=%0b exp=0", i, bus.dm_stall); end
      cyc;
    end
    checks++; if (bus.wbuf_count !== 3'd4) begin failures++; $display("FAIL t4_full got=%0d exp=4", bus.wbuf_count); end
    drv(1, 32'h40, 1, 32'h10, 32'h104);
    checks++; if (bus.dm_stall !== 1'b1) begin failures++; $display("FAIL t4_stall got=%0b exp=1", bus.dm_stall); end
    cyc;
    checks++; if (bus.wbuf_count !== 3'd4) begin failures++; $display("FAIL t4_held got=%0d exp=4", bus.wbuf_count); end
    drv(0, 32'h40, 1, 32'h10, 32'h104);
    checks++; if (bus.dm_stall !== 1'b0) begin failures++; $display("FAIL t4_release got=%0b exp=0", bus.dm_stall); end
    cyc;
    checks++; if (bus.wbuf_count !== 3'd4) begin failures++; $display("FAIL t4_pushpop got=%0d exp=4", bus.wbuf_count); end
    drv(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc;
    checks++; if (bus.wbuf_empty !== 1'b1) begin failures++; $display("FAIL t4_drained got=%0b exp=1", bus.wbuf_empty); end
    for (int i = 0; i < 5; i++) begin
      drv(1, 32'(i * 4), 0, 0, 0);
      checks++; if (bus.dm_read_data !== 32'h100 + 32'(i)) begin failures++; $display("FAIL t4_data_%0d got=%h exp=%h", i, bus.dm_read_data, 32'h100 + 32'(i)); end
    end
    drv(0, 0, 0, 0, 0);
  endtask

  task automatic test_wrap_alias;
    drv(0, 0, 1, 32'h1000, 32'hA5); cyc;
    drv(0, 0, 0, 0, 0); cyc;
    drv(1, 32'h0, 0, 0, 0);
    checks++; if (bus.dm_read_data !== 32'hA5) begin failures++; $display("FAIL t5_alias got=%h exp=a5", bus.dm_read_data); end
    for (int i = 0; i < 12; i++) begin
      drv(0, 0, 1, 32'h200 + 32'(i * 4), 32'h5000 + 32'(i)); cyc;
    end
    // Same-address stores behind a held load must land in order.
    for (int i = 0; i < 3; i++) begin
      drv(1, 32'h40, 1, 32'h300, 32'h7000 + 32'(i)); cyc;
    end
    drv(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc;
    checks++; if (bus.wbuf_empty !== 1'b1) begin failures++; $display("FAIL t5_drained got=%0b exp=1", bus.wbuf_empty); end
    for (int i = 0; i < 12; i++) begin
      drv(1, 32'h200 + 32'(i * 4), 0, 0, 0);
      checks++; if (bus.dm_read_data !== 32'h5000 + 32'(i)) begin failures++; $display("FAIL t5_wrap_%0d got=%h exp=%h", i, bus.dm_read_data, 32'h5000 + 32'(i)); end
    end
    drv(1, 32'h300, 0, 0, 0);
    checks++; if (bus.dm_read_data !== 32'h7002) begin failures++; $display("FAIL t5_order got=%h exp=7002", bus.dm_read_data); end
    drv(0, 0, 0, 0, 0);
  endtask

  task automatic test_same_cycle;
    int n;
    drv(0, 0, 1, 32'h8, 32'd7); cyc;
    drv(0, 0, 0, 0, 0); cyc;
    drv(1, 32'h8, 1, 32'h8, 32'd9);
    checks++; if (bus.dm_read_data !== 32'd7) begin failures++; $display("FAIL t6_old got=%0d exp=7", bus.dm_read_data); end
    checks++; if (bus.dm_stall !== 1'b0) begin failures++; $display("FAIL t6_stall got=%0b exp=0", bus.dm_stall); end
    cyc;
    drv(1, 32'h8, 0, 0, 0);
    wait_nostall(n);
    checks++; if (n != (FWD == 1 ? 0 : 1)) begin failures++; $display("FAIL t6_stall_cycles got=%0d exp=%0d", n, (FWD == 1 ? 0 : 1)); end
    checks++; if (bus.dm_read_data !== 32'd9) begin failures++; $display("FAIL t6_new got=%0d exp=9", bus.dm_read_data); end
    drv(0, 0, 0, 0, 0); cyc; cyc;
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_youngest_hit;
    test_full_backpressure;
    test_wrap_alias;
    test_same_cycle;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
